// File: rtl/sdram_init_writer.sv
// sdram_init_writer: buffers {address, data} words offered by an upstream
// loader in a small FIFO and writes them to SDRAM over Avalon-MM.
//
// Parameters
//   FIFO_DEPTH     word buffer depth (power of two, 2..64)
//   ADDR_W         SDRAM word-address width
// Ports
//   clk50          sole clock, rising edge
//   reset          synchronous active-high reset
//   ram_we         upstream offers a word (held until accepted)
//   ram_address    word address of the offered word
//   ram_data       offered data word
//   ram_op_begun   accept strobe; the offered word is pushed this edge
//   up_init_done   upstream has offered every word
//   up_init_error  upstream initialization failed
//   avm_address    Avalon-MM word address (FIFO head)
//   avm_writedata  Avalon-MM write data (FIFO head)
//   avm_byteenable always both bytes
//   avm_write      Avalon-MM write request (FIFO not empty)
//   avm_waitrequest controller stall
//   words_written  count of completed Avalon writes (wraps)
//   load_done      every accepted word has reached SDRAM
//   load_error     sticky upstream error
module sdram_init_writer #(
   parameter int FIFO_DEPTH = 8,
   parameter int ADDR_W     = 25
) (
   input  logic              clk50,
   input  logic              reset,
   input  logic              ram_we,
   input  logic [ADDR_W-1:0] ram_address,
   input  logic [15:0]       ram_data,
   output logic              ram_op_begun,
   input  logic              up_init_done,
   input  logic              up_init_error,
   output logic [ADDR_W-1:0] avm_address,
   output logic [15:0]       avm_writedata,
   output logic [1:0]        avm_byteenable,
   output logic              avm_write,
   input  logic              avm_waitrequest,
   output logic [ADDR_W-1:0] words_written,
   output logic              load_done,
   output logic              load_error
);

   localparam int PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
   localparam int CW = $clog2(FIFO_DEPTH) + 1;
   localparam int EW = ADDR_W + 16;

   localparam logic [CW-1:0] DEPTH = CW'(FIFO_DEPTH);
   localparam logic [CW-1:0] ONE   = CW'(1);

   typedef enum logic [1:0] {
      RUN   = 2'd0,
      DRAIN = 2'd1,
      DONE  = 2'd2,
      ERROR = 2'd3
   } state_t;

   state_t state;
   state_t state_nx;

   logic [PW-1:0]  wr_ptr;
   logic [PW-1:0]  rd_ptr;
   logic [CW-1:0]  count;
   logic [EW-1:0]  mem [FIFO_DEPTH];
   logic [EW-1:0]  head;
   logic           push;
   logic           pop;
   logic           flush;
   logic           active;

   // Pushes only in RUN and only while there is room; a pop in the
   // same cycle does not free a slot for the offered word.
   assign push         = ram_we & (count < DEPTH) & (state == RUN);
   assign ram_op_begun = push;

   assign active    = (state == RUN) | (state == DRAIN);
   assign avm_write = active & (count != '0);
   assign pop       = avm_write & ~avm_waitrequest;

   // Storage is not reset, so the head is masked whenever it is not valid.
   assign head          = mem[rd_ptr];
   assign avm_address   = avm_write ? head[EW-1:16] : '0;
   assign avm_writedata = avm_write ? head[15:0] : '0;

   assign avm_byteenable = 2'b11;
   assign load_done      = (state == DONE);
   assign load_error     = (state == ERROR);

   always_comb begin
      state_nx = state;
      flush    = 1'b0;
      case (state)
         RUN: begin
            if (up_init_error) begin
               state_nx = ERROR;
               flush    = 1'b1;
            end else if (up_init_done) begin
               state_nx = DRAIN;
            end
         end
         DRAIN: begin
            // Finish on the edge that retires the last buffered word.
            if ((count == '0) || (pop && (count == ONE))) begin
               state_nx = DONE;
            end
         end
         DONE:    state_nx = DONE;
         ERROR:   state_nx = ERROR;
         default: state_nx = RUN;
      endcase
   end

   always_ff @(posedge clk50) begin
      if (reset) begin
         state         <= RUN;
         wr_ptr        <= '0;
         rd_ptr        <= '0;
         count         <= '0;
         words_written <= '0;
      end else begin
         state <= state_nx;
         if (pop) begin
            words_written <= words_written + ADDR_W'(1);
         end
         if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
         end else begin
            if (push) begin
               wr_ptr <= wr_ptr + PW'(1);
            end
            if (pop) begin
               rd_ptr <= rd_ptr + PW'(1);
            end
            case ({push, pop})
               2'b10:   count <= count + ONE;
               2'b01:   count <= count - ONE;
               default: count <= count;
            endcase
         end
      end
   end

   always_ff @(posedge clk50) begin
      if (push) begin
         mem[wr_ptr] <= {ram_address, ram_data};
      end
   end

endmodule

// File: tb/tb_sdram_init_writer.sv
// tb_sdram_init_writer: directed self-checking bench for sdram_init_writer.
// Linear sequence of stimulus steps with hand-computed expectations.
module tb_sdram_init_writer;

   localparam int AW = 25;

   logic          clk50 = 1'b0;
   logic          reset = 1'b1;
   logic          ram_we = 1'b0;
   logic [AW-1:0] ram_address = '0;
   logic [15:0]   ram_data = '0;
   logic          ram_op_begun;
   logic          up_init_done = 1'b0;
   logic          up_init_error = 1'b0;
   logic [AW-1:0] avm_address;
   logic [15:0]   avm_writedata;
   logic [1:0]    avm_byteenable;
   logic          avm_write;
   logic          avm_waitrequest = 1'b0;
   logic [AW-1:0] words_written;
   logic          load_done;
   logic          load_error;

   int vecs = 0;
   int errs = 0;

   logic [AW+15:0] q[$];

   sdram_init_writer #(
      .FIFO_DEPTH(8),
      .ADDR_W(AW)
   ) dut (
      .clk50(clk50),
      .reset(reset),
      .ram_we(ram_we),
      .ram_address(ram_address),
      .ram_data(ram_data),
      .ram_op_begun(ram_op_begun),
      .up_init_done(up_init_done),
      .up_init_error(up_init_error),
      .avm_address(avm_address),
      .avm_writedata(avm_writedata),
      .avm_byteenable(avm_byteenable),
      .avm_write(avm_write),
      .avm_waitrequest(avm_waitrequest),
      .words_written(words_written),
      .load_done(load_done),
      .load_error(load_error)
   );

   always #5 clk50 = ~clk50;

   task automatic chk(input string tag, input logic [31:0] obs,
                      input logic [31:0] exp);
      vecs++;
      assert (obs === exp) else begin
         errs++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk50);
      #1;
   endtask

   task automatic do_reset();
      reset = 1'b1;
      ram_we = 1'b0;
      up_init_done = 1'b0;
      up_init_error = 1'b0;
      avm_waitrequest = 1'b0;
      tick();
      reset = 1'b0;
   endtask

   // Offer one word that must be accepted in this cycle.
   task automatic offer(input logic [AW-1:0] a, input logic [15:0] d);
      ram_we = 1'b1;
      ram_address = a;
      ram_data = d;
      #1;
      chk("offer_accept", 32'(ram_op_begun), 32'd1);
      q.push_back({a, d});
      tick();
      ram_we = 1'b0;
   endtask

   initial begin
      int idx;
      int writes;
      logic [AW+15:0] e;

      // Reset state
      tick();
      do_reset();
      chk("rst_write", 32'(avm_write), 32'd0);
      chk("rst_addr", 32'(avm_address), 32'd0);
      chk("rst_data", 32'(avm_writedata), 32'd0);
      chk("rst_count", 32'(words_written), 32'd0);
      chk("rst_done", 32'(load_done), 32'd0);
      chk("rst_err", 32'(load_error), 32'd0);
      chk("rst_be", 32'(avm_byteenable), 32'd3);
      #1;
      chk("rst_begun", 32'(ram_op_begun), 32'd0);

      // Single word
      ram_we = 1'b1;
      ram_address = 25'h000010;
      ram_data = 16'hBEEF;
      #1;
      chk("single_begun", 32'(ram_op_begun), 32'd1);
      chk("single_nobypass", 32'(avm_write), 32'd0);
      tick();
      ram_we = 1'b0;
      chk("single_write", 32'(avm_write), 32'd1);
      chk("single_addr", 32'(avm_address), 32'h10);
      chk("single_data", 32'(avm_writedata), 32'hBEEF);
      tick();
      chk("single_count", 32'(words_written), 32'd1);
      chk("single_idle", 32'(avm_write), 32'd0);

      // Backpressure fill: 8 accepted, 9th refused
      avm_waitrequest = 1'b1;
      for (int i = 0; i < 8; i++) begin
         offer(AW'(32'h100 + i), 16'(32'hA000 + i));
      end
      ram_we = 1'b1;
      ram_address = 25'h000108;
      ram_data = 16'hA008;
      #1;
      chk("fill_9th_refused", 32'(ram_op_begun), 32'd0);
      chk("stall_head", 32'(avm_address), 32'h100);
      tick();
      chk("stall_hold_addr", 32'(avm_address), 32'h100);
      chk("stall_hold_data", 32'(avm_writedata), 32'hA000);
      chk("stall_count", 32'(words_written), 32'd1);

      // Release while full: no push in the popping cycle, retry next
      avm_waitrequest = 1'b0;
      #1;
      chk("full_pop_no_push", 32'(ram_op_begun), 32'd0);
      idx = 8;
      writes = 0;
      for (int c = 0; c < 40; c++) begin
         ram_we = (idx < 10);
         ram_address = AW'(32'h100 + idx);
         ram_data = 16'(32'hA000 + idx);
         #1;
         if (avm_write && !avm_waitrequest) begin
            chk("order_nonempty", 32'(q.size() != 0), 32'd1);
            if (q.size() != 0) begin
               e = q.pop_front();
               chk("order_addr", 32'(avm_address), 32'(e[AW+15:16]));
               chk("order_data", 32'(avm_writedata), 32'(e[15:0]));
               writes++;
            end
         end
         if (ram_op_begun) begin
            q.push_back({ram_address, ram_data});
            if (idx == 8) begin
               chk("retry_cycle", 32'(c), 32'd1);
            end
            idx++;
         end
         tick();
         if (idx == 10 && q.size() == 0) break;
      end
      ram_we = 1'b0;
      chk("bp_accepted", 32'(idx), 32'd10);
      chk("bp_writes", 32'(writes), 32'd10);
      chk("bp_count", 32'(words_written), 32'd11);
      chk("bp_idle", 32'(avm_write), 32'd0);

      // Drain with 3 words buffered
      do_reset();
      avm_waitrequest = 1'b1;
      for (int i = 0; i < 3; i++) begin
         offer(AW'(32'h200 + i), 16'(32'hC000 + i));
      end
      q.delete();
      up_init_done = 1'b1;
      tick();
      up_init_done = 1'b0;
      ram_we = 1'b1;
      ram_address = 25'h0002FF;
      #1;
      chk("drain_no_push", 32'(ram_op_begun), 32'd0);
      chk("drain_write", 32'(avm_write), 32'd1);
      chk("drain_not_done", 32'(load_done), 32'd0);
      ram_we = 1'b0;
      avm_waitrequest = 1'b0;
      tick();
      tick();
      chk("drain_last_addr", 32'(avm_address), 32'h202);
      chk("drain_pending", 32'(load_done), 32'd0);
      tick();
      chk("drain_done", 32'(load_done), 32'd1);
      chk("drain_count", 32'(words_written), 32'd3);
      chk("drain_idle", 32'(avm_write), 32'd0);
      ram_we = 1'b1;
      #1;
      chk("done_no_push", 32'(ram_op_begun), 32'd0);
      ram_we = 1'b0;

      // Error with 4 words buffered
      do_reset();
      chk("err_rst_done", 32'(load_done), 32'd0);
      avm_waitrequest = 1'b1;
      for (int i = 0; i < 4; i++) begin
         offer(AW'(32'h300 + i), 16'(32'hD000 + i));
      end
      q.delete();
      up_init_error = 1'b1;
      tick();
      up_init_error = 1'b0;
      chk("err_flag", 32'(load_error), 32'd1);
      chk("err_write", 32'(avm_write), 32'd0);
      ram_we = 1'b1;
      #1;
      chk("err_no_push", 32'(ram_op_begun), 32'd0);
      avm_waitrequest = 1'b0;
      tick();
      chk("err_still_idle", 32'(avm_write), 32'd0);
      chk("err_count", 32'(words_written), 32'd0);
      chk("err_sticky", 32'(load_error), 32'd1);
      ram_we = 1'b0;

      // Reset during a stalled write
      do_reset();
      chk("rst2_err", 32'(load_error), 32'd0);
      avm_waitrequest = 1'b1;
      offer(25'h000400, 16'h1234);
      offer(25'h000401, 16'h5678);
      q.delete();
      chk("stall_write", 32'(avm_write), 32'd1);
      reset = 1'b1;
      tick();
      reset = 1'b0;
      chk("rst_mid_write", 32'(avm_write), 32'd0);
      chk("rst_mid_count", 32'(words_written), 32'd0);
      chk("rst_mid_addr", 32'(avm_address), 32'd0);
      avm_waitrequest = 1'b0;
      tick();
      chk("rst_mid_flushed", 32'(avm_write), 32'd0);
      chk("rst_mid_count2", 32'(words_written), 32'd0);

      $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
      $finish;
   end

endmodule

// File: doc/sdram_init_writer.md
SDRAM_INIT_WRITER -- requirements
Module: sdram_init_writer

Interface
REQ-001 Parameter: FIFO_DEPTH, 8, word buffer depth; power of two, 2..64.
REQ-002 Parameter: ADDR_W, 25, word-address width of the 32Mx16 SDRAM.
REQ-003 Port: clk50  in  1  sole clock; all logic on rising edge.
REQ-004 Port: reset  in  1  synchronous, active-high reset.
REQ-005 Port: ram_we  in  1  upstream loader holds high while a word is offered.
REQ-006 Port: ram_address  in  ADDR_W  word address of the offered word.
REQ-007 Port: ram_data  in  16  offered data word.
REQ-008 Port: ram_op_begun  out  1  accept strobe to upstream.
REQ-009 Port: up_init_done  in  1  upstream has offered every word.
REQ-010 Port: up_init_error  in  1  upstream SD initialization failed.
REQ-011 Port: avm_address  out  ADDR_W  Avalon-MM word address to the SDRAM controller.
REQ-012 Port: avm_writedata  out  16  Avalon-MM write data.
REQ-013 Port: avm_byteenable  out  2  constant 2'b11.
REQ-014 Port: avm_write  out  1  Avalon-MM write request.
REQ-015 Port: avm_waitrequest  in  1  controller stall; write completes in a cycle where avm_write=1 and avm_waitrequest=0.
REQ-016 Port: words_written  out  ADDR_W  count of completed Avalon writes.
REQ-017 Port: load_done  out  1  every accepted word has been written to SDRAM.
REQ-018 Port: load_error  out  1  sticky copy of upstream error.

Function
REQ-019 The FIFO stores {address, data} pairs, FIFO_DEPTH entries, with read/write pointers that wrap modulo FIFO_DEPTH and a separate occupancy count 0..FIFO_DEPTH.
REQ-020 ram_op_begun is combinational: ram_we & (count < FIFO_DEPTH) & (state == RUN); when it is high, the pair is pushed on that clock edge (exactly one push per strobe cycle).
REQ-021 When the FIFO is full, ram_op_begun stays 0 even if a pop occurs in the same cycle; a push is retried the next cycle.
REQ-022 There is no bypass: a word pushed at edge N appears on avm_* no earlier than the cycle after edge N.
REQ-023 avm_write = (count != 0); avm_address/avm_writedata are the FIFO head, held stable while avm_waitrequest=1.
REQ-024 Pop on avm_write & ~avm_waitrequest; a simultaneous push and pop leaves the count unchanged.
REQ-025 words_written increments by 1 per pop and wraps at 2^ADDR_W.
REQ-026 FSM states: RUN, DRAIN, DONE, ERROR.
REQ-027 RUN -> ERROR when up_init_error=1 (error has priority); RUN -> DRAIN when up_init_done=1.
REQ-028 DRAIN: no pushes; pops continue; DRAIN -> DONE on the edge where count becomes 0, or immediately if it is already 0.
REQ-029 DONE: load_done=1, avm_write=0, terminal until reset.
REQ-030 ERROR: load_error=1, FIFO flushed (count=0) on entry, avm_write=0, terminal until reset.
REQ-031 Incoming addresses are forwarded unmodified; no ordering or range checks are performed.

Reset
REQ-032 While reset=1 at an edge: state=RUN, pointers=0, count=0, words_written=0, load_done=0, load_error=0.
REQ-033 The cycle after reset: avm_write=0, avm_address=0, avm_writedata=0, and ram_op_begun follows REQ-020.
REQ-034 Reset mid-operation discards buffered words, including one held under waitrequest; the SDRAM controller shares this reset.

Verification
REQ-035 Single word: ram_we with addr 0x000010 and data 0xBEEF, waitrequest=0 -> ram_op_begun=1 in the same cycle; the next cycle avm_write=1, address 0x000010, data 0xBEEF; words_written=1.
REQ-036 Backpressure fill: waitrequest=1 while 10 words are offered -> exactly 8 accepted, ram_op_begun=0 on the 9th; release -> 8 writes in order, then the 9th and 10th are accepted.
REQ-037 Full plus simultaneous pop: FIFO full and waitrequest drops in the same cycle as ram_we -> no push that cycle, push on the next cycle; no word lost or duplicated.
REQ-038 Drain: up_init_done asserted with 3 words buffered -> load_done rises the cycle after the 3rd write completes; words_written=3.
REQ-039 Error: up_init_error with 4 words buffered -> load_error=1, avm_write=0 the next cycle, and no further ram_op_begun.
REQ-040 Reset during stalled write: reset=1 while avm_write=1 and waitrequest=1 -> the next cycle avm_write=0, count=0, words_written=0.
